// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Collects the registered results of the four ALU units (arith, logic,
//   compare, shift). Each cycle with any unit flag high pushes one tagged
//   entry into a first-word-fall-through FIFO. The FIFO drains to a
//   consumer over a valid/ready handshake.
//
// Ports
//   CLK, RST                  clock (rising edge), async active-high reset
//   Arith_OUT/Carry_OUT/Arith_Flag, Logic_OUT/Logic_Flag,
//   CMP_OUT/CMP_Flag, SHIFT_OUT/SHIFT_Flag
//                             unit results with 1-cycle valid pulses
//   Res_Ready                 consumer accepts the head entry
//   Clr_Err                   clears Overflow/Collision on the next edge
//   Res_Valid/Res_Data/Res_Carry/Res_Unit
//                             head entry; data fields are 0 while empty
//   Count                     occupied entries, 0..Depth
//   Overflow                  sticky: a result was dropped while full
//   Collision                 sticky: more than one unit flag in a cycle
//   Res_Parity                even parity of {Res_Unit, Res_Carry, Res_Data};
//                             present only when ALU_RESULT_PARITY_EN is defined
//
// Optional feature macro: ALU_RESULT_PARITY_EN

module alu_result_collector #(
  parameter int Width = 16,
  parameter int Depth = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [Width-1:0]         Arith_OUT,
  input  logic                     Carry_OUT,
  input  logic                     Arith_Flag,
  input  logic [Width-1:0]         Logic_OUT,
  input  logic                     Logic_Flag,
  input  logic [Width-1:0]         CMP_OUT,
  input  logic                     CMP_Flag,
  input  logic [Width-1:0]         SHIFT_OUT,
  input  logic                     SHIFT_Flag,
  input  logic                     Res_Ready,
  input  logic                     Clr_Err,
  output logic                     Res_Valid,
  output logic [Width-1:0]         Res_Data,
  output logic                     Res_Carry,
  output logic [1:0]               Res_Unit,
  output logic [$clog2(Depth):0]   Count,
  output logic                     Overflow,
  output logic                     Collision
`ifdef ALU_RESULT_PARITY_EN
 ,output logic                     Res_Parity
`endif
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

  typedef struct packed {
    unit_e            unit;
    logic             carry;
    logic [Width-1:0] data;
`ifdef ALU_RESULT_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  entry_t          mem_q [Depth];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            collision_q, collision_d;

  logic            wr_req;
  logic            wr_en;
  logic            pop;
  logic            full;
  logic            valid;
  logic            ovf_evt;
  logic            col_evt;
  entry_t          wr_entry;
  entry_t          head;

  always_comb begin
    wr_req   = Arith_Flag | Logic_Flag | CMP_Flag | SHIFT_Flag;
    col_evt  = (Arith_Flag & (Logic_Flag | CMP_Flag | SHIFT_Flag)) |
               (Logic_Flag & (CMP_Flag | SHIFT_Flag)) |
               (CMP_Flag & SHIFT_Flag);

    // Fixed priority: arith > logic > cmp > shift.
    wr_entry = '0;
    if (Arith_Flag) begin
      wr_entry.unit  = UNIT_ARITH;
      wr_entry.carry = Carry_OUT;
      wr_entry.data  = Arith_OUT;
    end else if (Logic_Flag) begin
      wr_entry.unit  = UNIT_LOGIC;
      wr_entry.data  = Logic_OUT;
    end else if (CMP_Flag) begin
      wr_entry.unit  = UNIT_CMP;
      wr_entry.data  = CMP_OUT;
    end else if (SHIFT_Flag) begin
      wr_entry.unit  = UNIT_SHIFT;
      wr_entry.data  = SHIFT_OUT;
    end
`ifdef ALU_RESULT_PARITY_EN
    wr_entry.parity = ^{wr_entry.unit, wr_entry.carry, wr_entry.data};
`endif

    valid    = (count_q != '0);
    full     = (count_q == CW'(Depth));
    pop      = valid & Res_Ready;
    // When full, a simultaneous pop frees the slot the write lands in.
    wr_en    = wr_req & (~full | pop);
    ovf_evt  = wr_req & full & ~pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);

    // Set wins over clear when both land in the same cycle.
    overflow_d  = (overflow_q  & ~Clr_Err) | ovf_evt;
    collision_d = (collision_q & ~Clr_Err) | col_evt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      collision_q <= collision_d;
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    Res_Valid = valid;
    Res_Data  = valid ? head.data  : '0;
    Res_Carry = valid ? head.carry : 1'b0;
    Res_Unit  = valid ? head.unit  : 2'b00;
`ifdef ALU_RESULT_PARITY_EN
    Res_Parity = valid ? head.parity : 1'b0;
`endif
    Count     = count_q;
    Overflow  = overflow_q;
    Collision = collision_q;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the ALU top level.
- Consumes the four registered unit results (arithmetic, logic, compare, shift) and their per-unit valid flags.
- Each flagged result is tagged with its source unit and pushed into a small first-word-fall-through (FWFT) FIFO.
- The FIFO is drained over a valid/ready handshake toward the writeback or host interface.
- Decouples single-cycle ALU result pulses from a consumer that may stall.

Parameters:
- Width, 16, data width of every unit result and of Res_Data.
- Depth, 4, FIFO entries; power of two, minimum 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- Arith_OUT  input  Width  arithmetic unit result.
- Carry_OUT  input  1  arithmetic carry.
- Arith_Flag  input  1  arithmetic result valid, 1-cycle pulse.
- Logic_OUT  input  Width  logic unit result.
- Logic_Flag  input  1  logic result valid.
- CMP_OUT  input  Width  compare unit result.
- CMP_Flag  input  1  compare result valid.
- SHIFT_OUT  input  Width  shift unit result.
- SHIFT_Flag  input  1  shift result valid.
- Res_Ready  input  1  consumer accepts the head entry.
- Clr_Err  input  1  clears sticky error flags.
- Res_Valid  output  1  head entry present.
- Res_Data  output  Width  head result.
- Res_Carry  output  1  head carry; 0 for non-arith entries.
- Res_Unit  output  2  head source: 00 arith, 01 logic, 10 cmp, 11 shift.
- Count  output  clog2(Depth)+1  occupied entries.
- Overflow  output  1  sticky: a result was dropped because the FIFO was full.
- Collision  output  1  sticky: more than one unit flag was high in one cycle.

Behaviour:
- Reset (async, RST=1):
  - Pointers and Count cleared to 0.
  - Res_Valid=0, Overflow=0, Collision=0.
  - Storage contents need not be reset.
  - Reset mid-operation discards all queued entries.
- Write request: asserted in any cycle where any flag is high.
  - Fixed priority when several flags are high: Arith > Logic > CMP > SHIFT.
  - Only the highest-priority result is stored.
  - Collision is set in that cycle.
- Stored entry: {unit code, carry, data}.
  - Carry = Carry_OUT for arith entries, otherwise 0.
- Latency: a flag at edge N makes the entry visible at the head (Res_Valid=1) after edge N+1 when the FIFO was empty.
- Read side:
  - Res_Valid = (Count != 0).
  - Pop occurs on a rising edge with Res_Valid & Res_Ready.
  - Head outputs update the following cycle.
  - Res_Data, Res_Carry and Res_Unit are forced to 0 while Res_Valid=0.
  - Res_Ready while empty has no effect.
- Full, write without pop: entry dropped, Overflow set, Count stays Depth.
- Full, write with pop in the same cycle: both happen, Count unchanged, no overflow.
- Empty, write with Res_Ready=1: no pop that cycle (nothing is valid); entry is stored.
- Pointers wrap modulo Depth. Count ranges 0..Depth.
- Clr_Err clears Overflow and Collision on the next edge. If a new error event occurs in the same cycle, set wins.
- Once presented, head entry values stay stable until popped.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- Defined:
  - Extra output Res_Parity (1 bit) = even parity over {Res_Unit, Res_Carry, Res_Data} of the head entry.
  - Parity is computed at write time and stored per entry.
  - Forced to 0 when Res_Valid=0.
- Undefined:
  - Port absent, storage width unchanged from base.
  - All other behaviour identical.

Test Plan:
- Reset then idle -> Res_Valid=0, Count=0, Res_Data=0x0000, Overflow=0, Collision=0.
- Arith_Flag pulse, Arith_OUT=0xFFFE, Carry_OUT=1, Res_Ready=0 -> next cycle Res_Valid=1, Res_Data=0xFFFE, Res_Carry=1, Res_Unit=00, Count=1.
- Logic_Flag and SHIFT_Flag high together (0x00AA, 0x0F00) -> entry 0x00AA, Res_Unit=01, Count=1, Collision=1. Then Clr_Err -> Collision=0.
- Five consecutive CMP_Flag pulses (0x0001..0x0005), Res_Ready=0, Depth=4 -> Count=4, Overflow=1. Then Res_Ready=1 drains 0x0001..0x0004 in order, Res_Unit=10, Res_Carry=0, then Res_Valid=0.
- FIFO full, Res_Ready=1, SHIFT_Flag with 0x8000 in the same cycle -> Count stays 4, Overflow stays 0, 0x8000 appears after the 3 older entries.
- RST pulsed mid-burst with Count=3 -> Res_Valid=0 and Count=0 immediately (async). Next Arith_Flag 0x1234 -> head is 0x1234.
